// File: rtl/mux_scan_ctrl.sv
// Select sequencer/sampler in front of a 4:1 mux: walks enabled channels, holds each
// for dwell+1 cycles, captures mux_out per channel. Continuous scanning via MUX_SCAN_CONT_EN.
module mux_scan_ctrl #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef MUX_SCAN_CONT_EN
    input  logic               cont,
`endif
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         chan_mask,
    input  logic               mux_out,
    output logic               s0,
    output logic               s1,
    output logic               busy,
    output logic               done,
    output logic [3:0]         sample,
    output logic               sample_valid
);

    typedef enum logic [1:0] {IDLE, CH, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3:0]         mask_q, mask_d;
    logic [3:0]         sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2:0]         pick;

    // Lowest enabled channel at index >= lo; result is {found, index}.
    function automatic logic [2:0] find_ch(input logic [3:0] m, input logic [2:0] lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= lo)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        dwell_d  = dwell_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        valid_d  = valid_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pick     = 3'b000;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dwell_d  = dwell;
                    mask_d   = chan_mask;
                    sample_d = 4'b0000;
                    valid_d  = 1'b0;
                    pick     = find_ch(chan_mask, 3'd0);
                    if (pick[2]) begin
                        state_d = CH;
                        ch_d    = pick[1:0];
                        cnt_d   = dwell;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            CH: begin
                busy_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    sample_d[ch_q] = mux_out;
                    pick = find_ch(mask_q, 3'({1'b0, ch_q}) + 3'd1);
                    if (pick[2]) begin
                        ch_d  = pick[1:0];
                        cnt_d = dwell_q;
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef MUX_SCAN_CONT_EN
                // Re-enter the scan without clearing the snapshot.
                if (cont) begin
                    pick = find_ch(mask_q, 3'd0);
                    if (pick[2]) begin
                        state_d = CH;
                        ch_d    = pick[1:0];
                        cnt_d   = dwell_q;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= 2'b00;
            cnt_q    <= '0;
            dwell_q  <= '0;
            mask_q   <= 4'b0000;
            sample_q <= 4'b0000;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            dwell_q  <= dwell_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign s0           = ch_q[1];
    assign s1           = ch_q[0];
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule
